// File: rtl/md_pad_pkg.sv
// Shared constants for the Mega Drive pad emulation: button indices, phase codes, timeout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package md_pad_pkg;

  // Host button vector bit positions (active-high)
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  // TH-low pulse count values that change the decode
  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_XYZ  = 3'd3;
  localparam logic [2:0] PH_HI   = 3'd4;

  // ~1.5 ms at 53.69 MHz
  localparam int TIMEOUT_DEF = 80000;

endpackage

// File: rtl/md_pad_timeout.sv
// Saturating idle timer; expire is high while the timer sits at TIMEOUT-1.
// Latency: clr takes effect on the next MCLK2 edge; expire is combinational from the count.
// Backpressure: none, free-running.
module md_pad_timeout #(
  parameter int TIMEOUT = 80000,
  parameter int TW      = 17
) (
  input  logic MCLK2,
  input  logic SRES,
  input  logic clr,
  output logic expire
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  assign expire = (timer == LAST);

  // Count up while idle, stop at LAST, restart from zero on any TH activity
  always_ff @(posedge MCLK2 or negedge SRES) begin
    if (!SRES) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (!expire) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/md_pad6.sv
// Mega Drive 3/6-button pad: TH-select mux, TH-low pulse counter, idle timeout.
// Latency: 1 MCLK2 cycle from port_o/port_d to port_i.
// Backpressure: none; pin levels are produced every cycle.
module md_pad6
  import md_pad_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 17
) (
  input  logic        MCLK2,
  input  logic        SRES,
  input  logic [6:0]  port_o,
  input  logic [6:0]  port_d,
  output logic [6:0]  port_i,
  input  logic [11:0] btn,
  input  logic        six_en,
  output logic [2:0]  phase
);

  logic        th;
  logic        th_q;
  logic        rise;
  logic        fall;
  logic [11:0] btn_q;
  logic        six_q;
  logic        six_chg;
  logic        expire;
  logic [2:0]  phase_nxt;
  logic [5:0]  d;

  // An undriven TH pin is pulled high by the pad
  assign th      = port_d[6] ? 1'b1 : port_o[6];
  assign rise    = th & ~th_q;
  assign fall    = ~th & th_q;
  // six_q is about to change this edge
  assign six_chg = (six_en != six_q);

  md_pad_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timeout (
    .MCLK2  (MCLK2),
    .SRES   (SRES),
    .clr    (rise | fall | six_chg),
    .expire (expire)
  );

  // Next pulse count: a fall landing on expiry counts as the first pulse of a new sequence
  always_comb begin
    phase_nxt = phase;
    if (six_chg || !six_q) begin
      phase_nxt = PH_IDLE;
    end else if (fall && expire) begin
      phase_nxt = 3'd1;
    end else if (fall) begin
      phase_nxt = (phase == PH_HI) ? PH_HI : phase + 3'd1;
    end else if (expire && !rise) begin
      phase_nxt = PH_IDLE;
    end
  end

  // Active-low pad data selected by current TH and the count it produces
  always_comb begin
    d = 6'h3f;
    if (th) begin
      if (phase_nxt == PH_XYZ) begin
        d = {~btn_q[BTN_C], ~btn_q[BTN_B], ~btn_q[BTN_MODE],
             ~btn_q[BTN_X], ~btn_q[BTN_Y], ~btn_q[BTN_Z]};
      end else begin
        d = {~btn_q[BTN_C], ~btn_q[BTN_B], ~btn_q[BTN_RIGHT],
             ~btn_q[BTN_LEFT], ~btn_q[BTN_DOWN], ~btn_q[BTN_UP]};
      end
    end else begin
      if (phase_nxt == PH_XYZ) begin
        d = {~btn_q[BTN_START], ~btn_q[BTN_A], 4'b0000};
      end else if (phase_nxt == PH_HI) begin
        d = {~btn_q[BTN_START], ~btn_q[BTN_A], 4'b1111};
      end else begin
        d = {~btn_q[BTN_START], ~btn_q[BTN_A], 2'b00,
             ~btn_q[BTN_DOWN], ~btn_q[BTN_UP]};
      end
    end
  end

  // Register inputs, pulse count and pin levels; console drive wins over pad data (wired-AND)
  always_ff @(posedge MCLK2 or negedge SRES) begin
    if (!SRES) begin
      th_q   <= 1'b1;
      btn_q  <= '0;
      six_q  <= 1'b0;
      phase  <= PH_IDLE;
      port_i <= 7'h7f;
    end else begin
      th_q   <= th;
      btn_q  <= btn;
      six_q  <= six_en;
      phase  <= phase_nxt;
      port_i <= {th, d & (port_d[5:0] | port_o[5:0])};
    end
  end

endmodule

// File: tb/tb_md_pad6.sv
module tb_md_pad6;

  localparam int TO  = 100;
  localparam int TWB = 7;
  // TH driven by console, data lines left as pulled-up inputs
  localparam logic [6:0] HI_O = 7'h40;
  localparam logic [6:0] LO_O = 7'h00;
  localparam logic [6:0] TH_D = 7'h3f;

  logic        MCLK2 = 1'b0;
  logic        SRES  = 1'b0;
  logic [6:0]  port_o = 7'h3f;
  logic [6:0]  port_d = 7'h40;
  logic [6:0]  port_i;
  logic [11:0] btn = '0;
  logic        six_en = 1'b0;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] e;

  always #5 MCLK2 = ~MCLK2;

  md_pad6 #(.TIMEOUT(TO), .TW(TWB)) dut (
    .MCLK2  (MCLK2),
    .SRES   (SRES),
    .port_o (port_o),
    .port_d (port_d),
    .port_i (port_i),
    .btn    (btn),
    .six_en (six_en),
    .phase  (phase)
  );

  // One clock with the given pin drive; outputs settle #1 after the edge
  task automatic cyc(input logic [6:0] o, input logic [6:0] dd);
    port_o = o;
    port_d = dd;
    @(posedge MCLK2);
    #1;
  endtask

  // As cyc, but records the port_i value expected after this edge
  task automatic drive(input logic [6:0] o, input logic [6:0] dd, input logic [6:0] ex);
    exp_q.push_back(ex);
    cyc(o, dd);
  endtask

  task automatic apply_reset();
    SRES = 1'b0;
    #2;
    SRES = 1'b1;
  endtask

  task automatic test_reset();
    SRES = 1'b0; btn = 12'hfff; six_en = 1'b0; port_o = 7'h3f; port_d = 7'h40;
    @(posedge MCLK2); #1;
    checks++; if (port_i !== 7'h7f) begin errors++; $display("FAIL reset_port_i got %h want 7f", port_i); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
    SRES = 1'b1;
    // btn_q is still clear on the first edge, so no buttons appear yet
    drive(7'h3f, 7'h40, 7'h7f);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL release_first got %h want %h", port_i, e); end
    // all buttons now visible: TH=1 lines all low
    drive(7'h3f, 7'h40, 7'h40);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL release_all_pressed got %h want %h", port_i, e); end
  endtask

  task automatic test_3btn();
    apply_reset();
    btn = 12'h091;  // Up | A | Start
    six_en = 1'b0;
    cyc(HI_O, TH_D); cyc(HI_O, TH_D);
    for (int p = 0; p < 5; p++) begin
      // TH=0: {~Start,~A,0,0,~Down,~Up} = 000010
      drive(LO_O, TH_D, 7'h02);
      e = exp_q.pop_front();
      checks++; if (port_i !== e) begin errors++; $display("FAIL 3btn_lo[%0d] got %h want %h", p, port_i, e); end
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL 3btn_phase[%0d] got %0d want 0", p, phase); end
      // TH=1: {~C,~B,~R,~L,~D,~U} = 111110
      drive(HI_O, TH_D, 7'h7e);
      e = exp_q.pop_front();
      checks++; if (port_i !== e) begin errors++; $display("FAIL 3btn_hi[%0d] got %h want %h", p, port_i, e); end
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL 3btn_phase_hi[%0d] got %0d want 0", p, phase); end
    end
  endtask

  task automatic test_6btn();
    logic [6:0] lo_exp [5];
    logic [6:0] hi_exp [5];
    logic [2:0] ph_exp [5];
    // X | Mode pressed
    lo_exp = '{7'h33, 7'h33, 7'h30, 7'h3f, 7'h3f};
    hi_exp = '{7'h7f, 7'h7f, 7'h73, 7'h7f, 7'h7f};
    ph_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    apply_reset();
    btn = 12'h900;
    six_en = 1'b1;
    cyc(HI_O, TH_D); cyc(HI_O, TH_D);
    for (int p = 0; p < 5; p++) begin
      drive(LO_O, TH_D, lo_exp[p]);
      e = exp_q.pop_front();
      checks++; if (port_i !== e) begin errors++; $display("FAIL 6btn_lo[%0d] got %h want %h", p, port_i, e); end
      checks++; if (phase !== ph_exp[p]) begin errors++; $display("FAIL 6btn_phase[%0d] got %0d want %0d", p, phase, ph_exp[p]); end
      for (int k = 0; k < 4; k++) cyc(LO_O, TH_D);
      drive(HI_O, TH_D, hi_exp[p]);
      e = exp_q.pop_front();
      checks++; if (port_i !== e) begin errors++; $display("FAIL 6btn_hi[%0d] got %h want %h", p, port_i, e); end
      for (int k = 0; k < 4; k++) cyc(HI_O, TH_D);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    btn = '0;
    six_en = 1'b1;
    cyc(HI_O, TH_D); cyc(HI_O, TH_D);
    cyc(LO_O, TH_D); cyc(HI_O, TH_D);
    cyc(LO_O, TH_D); cyc(HI_O, TH_D);  // last rise clears the timer
    for (int k = 0; k < TO - 1; k++) cyc(HI_O, TH_D);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL to_before_expiry got %0d want 2", phase); end
    cyc(HI_O, TH_D);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL to_expired got %0d want 0", phase); end
    // new sequence counts from 1
    drive(LO_O, TH_D, 7'h33);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL to_restart_lo got %h want %h", port_i, e); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL to_restart_phase got %0d want 1", phase); end
    cyc(HI_O, TH_D);
    cyc(LO_O, TH_D);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL to_second_pulse got %0d want 2", phase); end
    cyc(HI_O, TH_D);
    // fall exactly on the expiry cycle restarts at 1, not 3
    for (int k = 0; k < TO - 1; k++) cyc(HI_O, TH_D);
    drive(LO_O, TH_D, 7'h33);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL to_fall_on_expiry_pins got %h want %h", port_i, e); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL to_fall_on_expiry got %0d want 1", phase); end
  endtask

  task automatic test_wired_and();
    apply_reset();
    btn = '0;
    six_en = 1'b0;
    cyc(HI_O, TH_D);
    drive(7'h3e, 7'h40, 7'h7e);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL wand_bit0 got %h want %h", port_i, e); end
    drive(7'h36, 7'h40, 7'h76);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL wand_bit3 got %h want %h", port_i, e); end
    drive(7'h00, 7'h7f, 7'h7f);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL wand_all_input got %h want %h", port_i, e); end
    // all driven, TH low: {1,1,0,0,1,1}
    drive(7'h3f, 7'h00, 7'h33);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL wand_th_low got %h want %h", port_i, e); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    btn = 12'h100;  // X
    six_en = 1'b1;
    cyc(HI_O, TH_D); cyc(HI_O, TH_D);
    for (int p = 0; p < 2; p++) begin
      cyc(LO_O, TH_D); cyc(HI_O, TH_D);
    end
    cyc(LO_O, TH_D);
    drive(HI_O, TH_D, 7'h7b);  // phase 3, TH=1: {1,1,~Mode,~X,~Y,~Z} = 111011
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL ar_xyz got %h want %h", port_i, e); end
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL ar_phase3 got %0d want 3", phase); end
    #2;
    SRES = 1'b0;
    #1;
    checks++; if (port_i !== 7'h7f) begin errors++; $display("FAIL ar_port_i got %h want 7f", port_i); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL ar_phase got %0d want 0", phase); end
    #1;
    SRES = 1'b1;
    cyc(HI_O, TH_D); cyc(HI_O, TH_D);
    drive(LO_O, TH_D, 7'h33);
    e = exp_q.pop_front();
    checks++; if (port_i !== e) begin errors++; $display("FAIL ar_restart got %h want %h", port_i, e); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL ar_restart_phase got %0d want 1", phase); end
  endtask

  initial begin
    test_reset();
    test_3btn();
    test_6btn();
    test_timeout();
    test_wired_and();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
